// File: rtl/alloc_pkg.sv
// Shared types and helpers for the separable locking allocator.
// Covers the arbitration-order selector and the index-width helper.
package alloc_pkg;

  typedef enum logic {INPUT_FIRST_E, OUTPUT_FIRST_E} alloc_mode_t;

  // Width of an index into n items (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/separable_locking_allocator_rr.sv
// Round-robin arbiter whose priority pointer advances only when the caller
// confirms, through update_i, that the granted index survived downstream.
module round_robin_arbiter_upd
  import alloc_pkg::*;
#(
  parameter int AGENTS_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AGENTS_NUM-1:0] requests_i,
  input  logic [AGENTS_NUM-1:0] update_i,
  output logic [AGENTS_NUM-1:0] grants_o
);

  localparam int IW = idx_w(AGENTS_NUM);

  logic [IW-1:0] ptr_q, ptr_d, win_idx, cand;
  logic          found;

  always_comb begin
    grants_o = '0;
    found    = 1'b0;
    win_idx  = '0;
    cand     = '0;
    for (int k = 0; k < AGENTS_NUM; k++) begin
      cand = IW'((int'(ptr_q) + k) % AGENTS_NUM);
      if (!found && requests_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    if (found) grants_o[win_idx] = 1'b1;
  end

  // Kept apart from the grant logic so update_i never feeds back into grants_o.
  always_comb begin
    ptr_d = ptr_q;
    if (found && update_i[win_idx])
      ptr_d = (win_idx == IW'(AGENTS_NUM - 1)) ? '0 : win_idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/separable_locking_allocator.sv
// Two-stage separable switch allocator with packet-level resource locking;
// arbiter pointers move only for grants that survive both stages.
module separable_locking_allocator
  import alloc_pkg::*;
#(
  parameter int AGENTS_NUM    = 4,
  parameter int RESOURCES_NUM = 6,
  parameter int INPUT_FIRST   = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0] requests_i,
  input  logic [AGENTS_NUM-1:0]                    release_i,
  output logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0] grants_o,
  output logic [RESOURCES_NUM-1:0]                 locked_o
);

  localparam int          RW   = idx_w(RESOURCES_NUM);
  localparam alloc_mode_t MODE = (INPUT_FIRST != 0) ? INPUT_FIRST_E : OUTPUT_FIRST_E;

  logic [AGENTS_NUM-1:0]                    lock_vld_q, lock_vld_d;
  logic [AGENTS_NUM-1:0][RW-1:0]            lock_res_q, lock_res_d;
  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0] lock_gnt, mreq, arb;
  logic [RESOURCES_NUM-1:0]                 res_locked;

  always_comb begin
    res_locked = '0;
    lock_gnt   = '0;
    for (int a = 0; a < AGENTS_NUM; a++) begin
      for (int r = 0; r < RESOURCES_NUM; r++) begin
        if (lock_vld_q[a] && (lock_res_q[a] == RW'(r))) begin
          res_locked[r]  = 1'b1;
          lock_gnt[a][r] = requests_i[a][r];
        end
      end
    end
  end

  // Locked rows and columns never reach the arbiters.
  always_comb begin
    mreq = '0;
    for (int a = 0; a < AGENTS_NUM; a++)
      for (int r = 0; r < RESOURCES_NUM; r++)
        mreq[a][r] = requests_i[a][r] & ~lock_vld_q[a] & ~res_locked[r];
  end

  if (MODE == INPUT_FIRST_E) begin : g_if
    logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0] s1;
    logic [RESOURCES_NUM-1:0][AGENTS_NUM-1:0] s1_t, arb_t;

    for (genvar a = 0; a < AGENTS_NUM; a++) begin : g_s1
      round_robin_arbiter_upd #(.AGENTS_NUM(RESOURCES_NUM)) u_arb (
        .clk(clk), .rst(rst), .requests_i(mreq[a]), .update_i(arb[a]), .grants_o(s1[a]));
    end

    always_comb begin
      s1_t = '0;
      for (int a = 0; a < AGENTS_NUM; a++)
        for (int r = 0; r < RESOURCES_NUM; r++) s1_t[r][a] = s1[a][r];
    end

    for (genvar r = 0; r < RESOURCES_NUM; r++) begin : g_s2
      round_robin_arbiter_upd #(.AGENTS_NUM(AGENTS_NUM)) u_arb (
        .clk(clk), .rst(rst), .requests_i(s1_t[r]), .update_i(arb_t[r]), .grants_o(arb_t[r]));
    end

    always_comb begin
      arb = '0;
      for (int a = 0; a < AGENTS_NUM; a++)
        for (int r = 0; r < RESOURCES_NUM; r++) arb[a][r] = arb_t[r][a];
    end
  end else begin : g_of
    logic [RESOURCES_NUM-1:0][AGENTS_NUM-1:0] mreq_t, s1_t, arb_t;
    logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0] s1;

    always_comb begin
      mreq_t = '0;
      for (int a = 0; a < AGENTS_NUM; a++)
        for (int r = 0; r < RESOURCES_NUM; r++) mreq_t[r][a] = mreq[a][r];
    end

    for (genvar r = 0; r < RESOURCES_NUM; r++) begin : g_s1
      round_robin_arbiter_upd #(.AGENTS_NUM(AGENTS_NUM)) u_arb (
        .clk(clk), .rst(rst), .requests_i(mreq_t[r]), .update_i(arb_t[r]), .grants_o(s1_t[r]));
    end

    always_comb begin
      s1 = '0;
      for (int a = 0; a < AGENTS_NUM; a++)
        for (int r = 0; r < RESOURCES_NUM; r++) s1[a][r] = s1_t[r][a];
    end

    for (genvar a = 0; a < AGENTS_NUM; a++) begin : g_s2
      round_robin_arbiter_upd #(.AGENTS_NUM(RESOURCES_NUM)) u_arb (
        .clk(clk), .rst(rst), .requests_i(s1[a]), .update_i(arb[a]), .grants_o(arb[a]));
    end

    always_comb begin
      arb_t = '0;
      for (int a = 0; a < AGENTS_NUM; a++)
        for (int r = 0; r < RESOURCES_NUM; r++) arb_t[r][a] = arb[a][r];
    end
  end

  assign grants_o = arb | lock_gnt;
  assign locked_o = res_locked;

  // A lock is taken only by a fresh arbitrated grant that is not also a tail.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_res_d = lock_res_q;
    for (int a = 0; a < AGENTS_NUM; a++) begin
      if (lock_vld_q[a]) begin
        if (release_i[a] && (lock_gnt[a] != '0)) lock_vld_d[a] = 1'b0;
      end else if ((arb[a] != '0) && !release_i[a]) begin
        lock_vld_d[a] = 1'b1;
        for (int r = 0; r < RESOURCES_NUM; r++)
          if (arb[a][r]) lock_res_d[a] = RW'(r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lock_vld_q <= '0;
    else     lock_vld_q <= lock_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) lock_res_q <= lock_res_d;
  end

endmodule
